// File: rtl/led_fader.sv
// LED fader: ramps brightness toward pulse & enable and drives a PWM LED output.
// Define GAMMA_EN for a squared (perceptual) duty curve; the default build is linear.
module led_fader #(
  parameter int          PWM_BITS = 8,
  parameter logic [31:0] STEP_DIV = 32'd46875
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                pulse,
  output logic                pwm,
  output logic [PWM_BITS-1:0] level,
  output logic                busy,
  output logic                settled
);

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RISE = 2'd1,
    ON   = 2'd2,
    FALL = 2'd3
  } state_t;

  localparam logic [PWM_BITS-1:0] LMAX = '1;
  localparam logic [PWM_BITS-1:0] LMIN = '0;

  state_t              state;
  state_t              state_nxt;
  logic [31:0]         presc;
  logic [31:0]         presc_nxt;
  logic [PWM_BITS-1:0] level_nxt;
  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] cmp;
  logic                tgt;
  logic                tick;
  logic                settled_nxt;

  assign tgt  = pulse & enable;
  assign busy = (state == RISE) | (state == FALL);
  assign tick = busy && (presc == STEP_DIV - 32'd1);

`ifdef GAMMA_EN
  logic [2*PWM_BITS-1:0] sq;
  assign sq  = level * level;
  assign cmp = sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign cmp = level;
`endif

  always_comb begin
    state_nxt   = state;
    level_nxt   = level;
    settled_nxt = 1'b0;
    presc_nxt   = presc;
    if (busy)
      presc_nxt = tick ? 32'd0 : presc + 32'd1;
    unique case (state)
      OFF: begin
        if (tgt) begin
          state_nxt = RISE;
          presc_nxt = 32'd0;
        end
      end
      RISE: begin
        // A reversal wins over a coincident tick.
        if (!tgt) begin
          state_nxt = FALL;
        end else if (tick) begin
          level_nxt = (level == LMAX) ? LMAX : level + 1'b1;
          if (level_nxt == LMAX) begin
            state_nxt   = ON;
            settled_nxt = 1'b1;
          end
        end
      end
      ON: begin
        if (!tgt) begin
          state_nxt = FALL;
          presc_nxt = 32'd0;
        end
      end
      FALL: begin
        if (tgt) begin
          state_nxt = RISE;
        end else if (tick) begin
          level_nxt = (level == LMIN) ? LMIN : level - 1'b1;
          if (level_nxt == LMIN) begin
            state_nxt   = OFF;
            settled_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = OFF;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= OFF;
      level   <= '0;
      presc   <= 32'd0;
      settled <= 1'b0;
    end else begin
      state   <= state_nxt;
      level   <= level_nxt;
      presc   <= presc_nxt;
      settled <= settled_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      pwm <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      pwm <= (level == LMAX) | (cnt < cmp);
    end
  end

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader: ramps, duty, reversal, enable gating, reset.
// Three instances: STEP_DIV 2 (main), 1 (fast) and 64 (duty windows).
module tb_led_fader;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       pulse;
  logic       pwm;
  logic [3:0] level;
  logic       busy;
  logic       settled;

  logic       pulse_f;
  logic       pwm_f;
  logic [3:0] level_f;
  logic       busy_f;
  logic       settled_f;

  logic       pulse_s;
  logic       pwm_s;
  logic [3:0] level_s;
  logic       busy_s;
  logic       settled_s;

  int n_chk  = 0;
  int n_pass = 0;
  int n;

  always #5 clock = ~clock;

  led_fader #(.PWM_BITS(4), .STEP_DIV(32'd2)) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .pulse   (pulse),
    .pwm     (pwm),
    .level   (level),
    .busy    (busy),
    .settled (settled)
  );

  led_fader #(.PWM_BITS(4), .STEP_DIV(32'd1)) u_fast (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (1'b1),
    .pulse   (pulse_f),
    .pwm     (pwm_f),
    .level   (level_f),
    .busy    (busy_f),
    .settled (settled_f)
  );

  led_fader #(.PWM_BITS(4), .STEP_DIV(32'd64)) u_slow (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (1'b1),
    .pulse   (pulse_s),
    .pwm     (pwm_s),
    .level   (level_s),
    .busy    (busy_s),
    .settled (settled_s)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input int cnt);
    repeat (cnt) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_idle(input int lim);
    int i;
    i = 0;
    do begin
      step(1);
      i++;
    end while (busy && i < lim);
    chk("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    pulse   = 1'b1;
    enable  = 1'b1;
    pulse_f = 1'b0;
    pulse_s = 1'b0;
    step(3);
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_settled", int'(settled), 0);

    reset_n = 1'b1;
    step(1);
    chk("entry_busy", int'(busy), 1);
    chk("entry_level", int'(level), 0);
    for (int k = 1; k <= 30; k++) begin
      step(1);
      chk("rise_level", int'(level), k / 2);
    end
    chk("on_busy", int'(busy), 0);
    chk("on_settled", int'(settled), 1);
    step(1);
    chk("on_settled_clr", int'(settled), 0);
    n = 0;
    repeat (16) begin
      step(1);
      n += int'(pwm);
    end
    chk("on_duty", n, 16);

    pulse = 1'b0;
    step(1);
    chk("fall_busy", int'(busy), 1);
    chk("fall_level", int'(level), 15);
    for (int j = 1; j <= 30; j++) begin
      step(1);
      chk("fall_level", int'(level), 15 - j / 2);
    end
    chk("off_busy", int'(busy), 0);
    chk("off_settled", int'(settled), 1);
    step(1);
    chk("off_settled_clr", int'(settled), 0);
    n = 0;
    repeat (16) begin
      step(1);
      n += int'(pwm);
    end
    chk("off_duty", n, 0);

    pulse = 1'b1;
    step(13);
    chk("rev_pre_level", int'(level), 6);
    pulse = 1'b0;
    step(1);
    chk("rev_busy", int'(busy), 1);
    chk("rev_level", int'(level), 6);
    chk("rev_settled", int'(settled), 0);
    step(1);
    chk("rev_step", int'(level), 5);
    pulse = 1'b1;
    step(1);
    chk("rerise_level", int'(level), 5);
    step(1);
    chk("rerise_step", int'(level), 6);
    step(1);
    chk("rerise_hold", int'(level), 6);
    pulse = 1'b0;
    step(1);
    chk("rev_tick_prio", int'(level), 6);
    chk("rev_tick_set", int'(settled), 0);
    step(1);
    chk("rev_tick_hold", int'(level), 6);
    step(1);
    chk("rev_tick_step", int'(level), 5);
    wait_idle(100);
    chk("rev_fade_level", int'(level), 0);

    pulse = 1'b1;
    wait_idle(100);
    chk("en_on_level", int'(level), 15);
    enable = 1'b0;
    step(1);
    chk("en_fall_busy", int'(busy), 1);
    chk("en_fall_level", int'(level), 15);
    step(2);
    chk("en_fall_step", int'(level), 14);
    wait_idle(100);
    chk("en_fade_level", int'(level), 0);
    pulse  = 1'b0;
    enable = 1'b1;

    pulse_f = 1'b1;
    step(1);
    for (int k = 1; k <= 15; k++) begin
      step(1);
      chk("fast_level", int'(level_f), k);
    end
    chk("fast_settled", int'(settled_f), 1);

    pulse_s = 1'b1;
    step(1);
    step(263);
    chk("slow_level4", int'(level_s), 4);
    n = 0;
    repeat (16) begin
      step(1);
      n += int'(pwm_s);
    end
`ifdef GAMMA_EN
    chk("duty_level4", n, 1);
`else
    chk("duty_level4", n, 4);
`endif
    step(240);
    chk("slow_level8", int'(level_s), 8);
    n = 0;
    repeat (16) begin
      step(1);
      n += int'(pwm_s);
    end
`ifdef GAMMA_EN
    chk("duty_level8", n, 4);
`else
    chk("duty_level8", n, 8);
`endif

    pulse = 1'b1;
    wait_idle(100);
    step(2);
    chk("pre_rst_pwm", int'(pwm), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_pwm", int'(pwm), 0);
    chk("async_rst_level", int'(level), 0);
    chk("async_rst_busy", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
